// File: rtl/frc_release_arbiter.sv
// Merges per-PE force-release streams through small FIFOs and a round-robin arbiter onto one
// registered valid/ready output. Optional ARB_STATS_EN adds grant/stall counters.
module frc_release_arbiter #(
  parameter int unsigned NUM_PE       = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned AFULL_THRESH = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NODE_W       = 8,
  localparam int unsigned PE_W        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W       = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PE*DATA_W-1:0] i_frc,
  input  logic [NUM_PE*NODE_W-1:0] i_node_id,
  input  logic [NUM_PE-1:0]        i_valid,
  output logic [DATA_W-1:0]        o_frc,
  output logic [NODE_W-1:0]        o_node_id,
  output logic [PE_W-1:0]          o_src_pe,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NUM_PE-1:0]        o_back_pressure,
  output logic [NUM_PE-1:0]        o_overflow,
`ifdef ARB_STATS_EN
  output logic [NUM_PE*32-1:0]     o_grant_cnt,
  output logic [31:0]              o_stall_cycles,
`endif
  output logic                     o_all_empty
);

  localparam int unsigned ENTRY_W = NODE_W + DATA_W;

  logic [ENTRY_W-1:0] mem_q    [NUM_PE][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_PE];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_PE];
  logic [CNT_W-1:0]   cnt_q    [NUM_PE];
  logic [CNT_W-1:0]   cnt_d    [NUM_PE];

  logic [PE_W-1:0]    rr_q, grant, scan_idx;
  logic [PE_W:0]      scan_sum;
  logic               found, load, all_empty_d;
  logic [NUM_PE-1:0]  pop, push, drop;
  logic [ENTRY_W-1:0] head;

  logic [DATA_W-1:0]  frc_q;
  logic [NODE_W-1:0]  node_q;
  logic [PE_W-1:0]    src_q;
  logic               valid_q, all_empty_q;
  logic [NUM_PE-1:0]  bp_q, ovf_q;

  // Round-robin scan: first non-empty FIFO at or after rr_q, cyclic.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      scan_sum = {1'b0, rr_q} + (PE_W + 1)'(i);
      if (scan_sum >= (PE_W + 1)'(NUM_PE)) scan_sum = scan_sum - (PE_W + 1)'(NUM_PE);
      scan_idx = scan_sum[PE_W-1:0];
      if (!found && cnt_q[scan_idx] != '0) begin
        found = 1'b1;
        grant = scan_idx;
      end
    end
    load = found && (!valid_q || i_ready);
    head = mem_q[grant][rd_ptr_q[grant]];
  end

  // A full FIFO still accepts when it is popped in the same cycle.
  always_comb begin
    all_empty_d = !(load || (valid_q && !i_ready));
    for (int k = 0; k < NUM_PE; k++) begin
      pop[k]   = load && (grant == PE_W'(k));
      push[k]  = i_valid[k] && ((cnt_q[k] != CNT_W'(FIFO_DEPTH)) || pop[k]);
      drop[k]  = i_valid[k] && !push[k];
      cnt_d[k] = cnt_q[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
      if (cnt_d[k] != '0) all_empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PE; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= {i_node_id[k*NODE_W +: NODE_W],
                                             i_frc[k*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_PE; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      rr_q        <= '0;
      valid_q     <= 1'b0;
      frc_q       <= '0;
      node_q      <= '0;
      src_q       <= '0;
      bp_q        <= '0;
      ovf_q       <= '0;
      all_empty_q <= 1'b1;
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        cnt_q[k] <= cnt_d[k];
        bp_q[k]  <= (cnt_q[k] >= CNT_W'(AFULL_THRESH));
      end
      ovf_q <= ovf_q | drop;
      if (load) begin
        valid_q <= 1'b1;
        frc_q   <= head[DATA_W-1:0];
        node_q  <= head[ENTRY_W-1:DATA_W];
        src_q   <= grant;
        rr_q    <= (grant == PE_W'(NUM_PE - 1)) ? '0 : grant + 1'b1;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
      all_empty_q <= all_empty_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] gcnt_q [NUM_PE];
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_PE; k++) gcnt_q[k] <= '0;
      stall_q <= '0;
    end else begin
      if (valid_q && i_ready && gcnt_q[src_q] != '1) gcnt_q[src_q] <= gcnt_q[src_q] + 1'b1;
      if (valid_q && !i_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  always_comb begin
    o_grant_cnt = '0;
    for (int k = 0; k < NUM_PE; k++) o_grant_cnt[k*32 +: 32] = gcnt_q[k];
  end
  assign o_stall_cycles = stall_q;
`endif

  assign o_frc           = frc_q;
  assign o_node_id       = node_q;
  assign o_src_pe        = src_q;
  assign o_valid         = valid_q;
  assign o_back_pressure = bp_q;
  assign o_overflow      = ovf_q;
  assign o_all_empty     = all_empty_q;

endmodule
